// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl
// ----------------------------------------------------------------------------
// Instruction issue controller and 16x16 register file in front of the
// datapath ALU.  Fetches 16-bit instruction words over a req/ack port,
// decodes them into an 8-bit ALU opcode plus two 16-bit operands, writes the
// registered ALU result back into the register file and resolves conditional
// branches from the ALU status flags.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   fetch_req   out  high while waiting for an instruction word
//   instr_addr  out  current program counter
//   fetch_ack   in   fetch_data valid this cycle (honoured only in FETCH)
//   fetch_data  in   instruction word
//   alu_opcode  out  ALU opcode (zero unless issuing)
//   alu_a       out  ALU operand A (zero unless issuing)
//   alu_b       out  ALU operand B (zero unless issuing)
//   alu_result  in   registered ALU result
//   alu_psr     in   ALU flags, [3]=Z, [1]=GT (unsigned)
//   dbg_sel     in   debug register select
//   dbg_data    out  combinational read of R[dbg_sel]
//
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        fetch_req,
    output logic [15:0] instr_addr,
    input  logic        fetch_ack,
    input  logic [15:0] fetch_data,
    output logic [7:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic [4:0]  alu_psr,
    input  logic [3:0]  dbg_sel,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  opc_q, opc_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        wb_q, wb_d;
    logic        rf_we;
    logic [15:0] rf_q [16];

    // Instruction fields
    logic [3:0]  op, rd, ext, rs;
    logic [7:0]  imm8;
    logic [15:0] rd_val, rs_val, br_off;
    logic        flag_z, flag_gt, br_taken;
    logic        unused_psr;

    assign op      = ir_q[15:12];
    assign rd      = ir_q[11:8];
    assign ext     = ir_q[7:4];
    assign rs      = ir_q[3:0];
    assign imm8    = ir_q[7:0];
    assign rd_val  = rf_q[rd];
    assign rs_val  = rf_q[rs];
    assign br_off  = {{8{imm8[7]}}, imm8};
    assign flag_z  = alu_psr[3];
    assign flag_gt = alu_psr[1];
    assign unused_psr = ^{alu_psr[4], alu_psr[2], alu_psr[0]};

    // Branch condition lives in the rd field
    always_comb begin
        br_taken = 1'b0;
        case (rd)
            4'b0000: br_taken = flag_z;
            4'b0001: br_taken = !flag_z;
            4'b0110: br_taken = flag_gt;
            4'b0111: br_taken = !flag_gt;
            4'b1110: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state / datapath control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        opc_d   = opc_q;
        a_d     = a_q;
        b_d     = b_q;
        wb_d    = wb_q;
        rf_we   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (fetch_ack) begin
                    ir_d    = fetch_data;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // Default decode is the register-register ALU form; the
                // other classes override fields below.
                opc_d   = {op, ext};
                a_d     = rd_val;
                b_d     = rs_val;
                wb_d    = 1'b1;
                state_d = S_EXEC;
                case (op)
                    4'b0000: begin
                        // CMP and NOP issue to the ALU but keep R[rd]
                        wb_d = !((ext == 4'b1011) || (ext == 4'b0000));
                    end
                    4'b1000: begin
                        // ext=0100 is the register-count shift; the rest
                        // take a 4-bit immediate from the rs field
                        if (ext != 4'b0100) begin
                            b_d = {12'b0, rs};
                        end
                    end
                    4'b1111: begin
                        opc_d = 8'hF0;
                        a_d   = 16'h0000;
                        b_d   = {8'b0, imm8};
                    end
                    4'b0100: begin
                        if (ext == 4'b1111) begin
                            opc_d = 8'h4F;
                            b_d   = 16'h0000;
                        end else begin
                            wb_d    = 1'b0;
                            pc_d    = pc_q + 16'd1;
                            state_d = S_FETCH;
                        end
                    end
                    4'b1100: begin
                        wb_d    = 1'b0;
                        pc_d    = br_taken ? (pc_q + br_off) : (pc_q + 16'd1);
                        state_d = S_FETCH;
                    end
                    default: begin
                        wb_d    = 1'b0;
                        pc_d    = pc_q + 16'd1;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_EXEC: begin
                state_d = S_WB;
            end

            S_WB: begin
                rf_we   = wb_q;
                pc_d    = pc_q + 16'd1;
                state_d = S_FETCH;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            opc_q   <= 8'h00;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wb_q    <= wb_d;
        end
    end

    // Register file
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else if (rf_we) begin
            rf_q[rd] <= alu_result;
        end
    end

    assign fetch_req  = (state_q == S_FETCH);
    assign instr_addr = pc_q;
    // ALU sees a live operation only during EXEC; otherwise it idles on zero
    assign alu_opcode = (state_q == S_EXEC) ? opc_q : 8'h00;
    assign alu_a      = (state_q == S_EXEC) ? a_q   : 16'h0000;
    assign alu_b      = (state_q == S_EXEC) ? b_q   : 16'h0000;
    assign dbg_data   = rf_q[dbg_sel];

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// tb_alu_issue_ctrl
// ----------------------------------------------------------------------------
// Bench for alu_issue_ctrl with a small behavioural ALU attached.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req;
    logic [15:0] instr_addr;
    logic        fetch_ack = 1'b0;
    logic [15:0] fetch_data = 16'h0000;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_result = 16'h0000;
    logic [4:0]  alu_psr = 5'b00000;
    logic [3:0]  dbg_sel = 4'h0;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_ctrl #(.RESET_PC(16'h0000)) dut (
        .clock      (clock),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .instr_addr (instr_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_psr    (alu_psr),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: result registered on the issuing edge, flags from CMP
    function automatic logic [15:0] alu_model(input logic [7:0] opc,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        logic [15:0] r;
        r = 16'hDEAD;
        if (opc == 8'h05)      r = a + b;
        else if (opc == 8'h09) r = a - b;
        else if (opc == 8'hF0) r = (b << 8) | a;    // a must be zero
        else if (opc == 8'h4F) r = a - 16'd1 - b;   // b must be zero
        else if (opc == 8'h84) r = a << b[3:0];
        else if (opc[7:4] == 4'h8) r = a >> b[3:0];
        return r;
    endfunction

    always_ff @(posedge clock) begin
        alu_result <= alu_model(alu_opcode, alu_a, alu_b);
        if (alu_opcode == 8'h0B)
            alu_psr <= {1'b0, (alu_a == alu_b), 1'b0, (alu_a > alu_b), 1'b0};
    end

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  rsel;
        logic [15:0] rval;
        logic [15:0] pc;
        int          cyc;
    } vec_t;

    vec_t tbl [28];
    vec_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [3:0] r, output logic [15:0] v);
        dbg_sel = r;
        #1;
        v = dbg_data;
    endtask

    // Deliver one instruction and wait until the controller is back in FETCH.
    task automatic run_instr(input logic [15:0] ins, output int cyc);
        int n;
        n = 0;
        while (!fetch_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        fetch_ack  = 1'b1;
        fetch_data = ins;
        @(posedge clock);
        cyc = 1;
        @(negedge clock);
        fetch_ack  = 1'b0;
        fetch_data = 16'($urandom);
        while (!fetch_req && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic run_and_score(input vec_t v);
        vec_t e;
        int   cyc;
        logic [15:0] rv;
        exp_q.push_back(v);
        run_instr(v.instr, cyc);
        e = exp_q.pop_front();
        read_reg(e.rsel, rv);
        check($sformatf("reg %h", e.instr), {16'h0, rv}, {16'h0, e.rval});
        check($sformatf("pc %h", e.instr), {16'h0, instr_addr}, {16'h0, e.pc});
        check($sformatf("cycles %h", e.instr), cyc, e.cyc);
    endtask

    task automatic check_reset_state();
        logic [15:0] rv;
        check("rst fetch_req", {31'h0, fetch_req}, 32'h1);
        check("rst instr_addr", {16'h0, instr_addr}, 32'h0);
        check("rst alu_opcode", {24'h0, alu_opcode}, 32'h0);
        check("rst alu_ab", {alu_a, alu_b}, 32'h0);
        for (int r = 0; r < 16; r += 5) begin
            read_reg(4'(r), rv);
            check($sformatf("rst R%0d", r), {16'h0, rv}, 32'h0);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] i, input logic [3:0] r,
                                input logic [15:0] v, input logic [15:0] p, input int c);
        vec_t t;
        t.instr = i; t.rsel = r; t.rval = v; t.pc = p; t.cyc = c;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [15:0] rv;

        tbl[0]  = mk(16'hF112, 4'd1, 16'h1200, 16'h0001, 4);
        tbl[1]  = mk(16'hF105, 4'd1, 16'h0500, 16'h0002, 4);
        tbl[2]  = mk(16'h8108, 4'd1, 16'h0005, 16'h0003, 4);
        tbl[3]  = mk(16'hF203, 4'd2, 16'h0300, 16'h0004, 4);
        tbl[4]  = mk(16'h8208, 4'd2, 16'h0003, 16'h0005, 4);
        tbl[5]  = mk(16'h0152, 4'd1, 16'h0008, 16'h0006, 4);
        tbl[6]  = mk(16'h0192, 4'd1, 16'h0005, 16'h0007, 4);
        tbl[7]  = mk(16'h8142, 4'd1, 16'h0028, 16'h0008, 4);
        tbl[8]  = mk(16'h41F0, 4'd1, 16'h0027, 16'h0009, 4);
        tbl[9]  = mk(16'hF107, 4'd1, 16'h0700, 16'h000A, 4);
        tbl[10] = mk(16'h8108, 4'd1, 16'h0007, 16'h000B, 4);
        tbl[11] = mk(16'hF207, 4'd2, 16'h0700, 16'h000C, 4);
        tbl[12] = mk(16'h8208, 4'd2, 16'h0007, 16'h000D, 4);
        tbl[13] = mk(16'h01B2, 4'd1, 16'h0007, 16'h000E, 4);
        tbl[14] = mk(16'h2000, 4'd1, 16'h0007, 16'h000F, 2);
        tbl[15] = mk(16'h2000, 4'd2, 16'h0007, 16'h0010, 2);
        tbl[16] = mk(16'hC004, 4'd1, 16'h0007, 16'h0014, 2);
        tbl[17] = mk(16'hC104, 4'd1, 16'h0007, 16'h0015, 2);
        tbl[18] = mk(16'hC604, 4'd1, 16'h0007, 16'h0016, 2);
        tbl[19] = mk(16'hC704, 4'd1, 16'h0007, 16'h001A, 2);
        tbl[20] = mk(16'h0000, 4'd0, 16'h0000, 16'h001B, 4);
        tbl[21] = mk(16'hF109, 4'd1, 16'h0900, 16'h001C, 4);
        tbl[22] = mk(16'h01B2, 4'd1, 16'h0900, 16'h001D, 4);
        tbl[23] = mk(16'hC604, 4'd1, 16'h0900, 16'h0021, 2);
        tbl[24] = mk(16'hC104, 4'd1, 16'h0900, 16'h0025, 2);
        tbl[25] = mk(16'hC004, 4'd1, 16'h0900, 16'h0026, 2);
        tbl[26] = mk(16'hC704, 4'd1, 16'h0900, 16'h0027, 2);
        tbl[27] = mk(16'h4120, 4'd1, 16'h0900, 16'h0028, 2);

        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state();

        for (int i = 0; i < 28; i++) begin
            run_and_score(tbl[i]);
        end

        // Stall: no ack for five cycles, garbage on fetch_data
        for (int i = 0; i < 5; i++) begin
            fetch_data = 16'($urandom);
            @(negedge clock);
            read_reg(4'd1, rv);
            check("stall", {fetch_req, instr_addr, rv[14:0]}, {1'b1, 16'h0028, 15'h0900});
        end

        // PC wrap via negative branch and increment past FFFF
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state();
        run_and_score(mk(16'h2000, 4'd0, 16'h0000, 16'h0001, 2));
        run_and_score(mk(16'hCEFE, 4'd0, 16'h0000, 16'hFFFF, 2));
        run_and_score(mk(16'h2000, 4'd0, 16'h0000, 16'h0000, 2));

        // Reset during WB of an ADD into R3 drops the writeback
        run_and_score(mk(16'hF301, 4'd3, 16'h0100, 16'h0001, 4));
        fetch_ack  = 1'b1;
        fetch_data = 16'h0353;
        @(posedge clock);             // -> DECODE
        #1 fetch_ack = 1'b0;
        @(posedge clock);             // -> EXEC
        @(posedge clock);             // -> WB
        #2 reset = 1'b1;
        #1;
        read_reg(4'd3, rv);
        check("async rst R3", {16'h0, rv}, 32'h0);
        check("async rst pc", {16'h0, instr_addr}, 32'h0);
        check("async rst fetch_req", {31'h0, fetch_req}, 32'h1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        read_reg(4'd3, rv);
        check("post rst R3", {16'h0, rv}, 32'h0);
        check("post rst pc", {16'h0, instr_addr}, 32'h0);
        check("post rst alu_opcode", {24'h0, alu_opcode}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
